// File: rtl/rf_write_queue_pkg.sv
// rf_write_queue_pkg: shared types and constants for the register-file write queue
package rf_write_queue_pkg;
    localparam int WQ_DEPTH  = 4;
    localparam int REG_IDX_W = 5;
    localparam int DATA_W    = 32;

    typedef struct packed {
        logic [REG_IDX_W-1:0] rd;
        logic [DATA_W-1:0]    data;
    } wq_entry_t;
endpackage

// File: rtl/rf_wq_fwd_lookup.sv
// rf_wq_fwd_lookup: youngest-match search of pending queue entries for one read port
module rf_wq_fwd_lookup
    import rf_write_queue_pkg::*;
#(
    parameter int DEPTH = WQ_DEPTH
) (
    input  wq_entry_t [DEPTH-1:0]      entries,
    input  logic [$clog2(DEPTH)-1:0]   head,
    input  logic [$clog2(DEPTH):0]     count,
    input  logic [REG_IDX_W-1:0]       rs,
    output logic                       hit,
    output logic [DATA_W-1:0]          data
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Walk from head towards tail so the last (youngest) valid match wins
    always_comb begin
        hit  = 1'b0;
        data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rs != '0 && CW'(i) < count && entries[head + PW'(i)].rd == rs) begin
                hit  = 1'b1;
                data = entries[head + PW'(i)].data;
            end
        end
    end
endmodule

// File: rtl/rf_write_queue.sv
// rf_write_queue: two-producer register-file write queue with forwarding and sticky overflow
module rf_write_queue
    import rf_write_queue_pkg::*;
#(
    parameter int DEPTH = WQ_DEPTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 mem_valid,
    input  logic [REG_IDX_W-1:0] mem_rd,
    input  logic [DATA_W-1:0]    mem_data,
    input  logic                 alu_valid,
    input  logic [REG_IDX_W-1:0] alu_rd,
    input  logic [DATA_W-1:0]    alu_data,
    input  logic [REG_IDX_W-1:0] rs1,
    input  logic [REG_IDX_W-1:0] rs2,
    output logic                 fwd1_hit,
    output logic                 fwd2_hit,
    output logic [DATA_W-1:0]    fwd1_data,
    output logic [DATA_W-1:0]    fwd2_data,
    output logic                 RegWrite,
    output logic [REG_IDX_W-1:0] Write_register,
    output logic [DATA_W-1:0]    Write_data,
    output logic                 stall,
    output logic                 overflow
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]         rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]         count_q, count_d, free_slots;
    logic                  overflow_q, overflow_d;
    wq_entry_t [DEPTH-1:0] slots_q, slots_d;
    logic                  deq, mem_req, alu_req, mem_acc, alu_acc;

    // Dequeue head every non-empty cycle; mem claims a free slot before ALU, freed head slot reusable
    always_comb begin
        deq        = count_q != '0;
        mem_req    = mem_valid && mem_rd != '0;
        alu_req    = alu_valid && alu_rd != '0;
        free_slots = CW'(DEPTH) - count_q + CW'(deq);
        mem_acc    = mem_req && free_slots != '0;
        alu_acc    = alu_req && free_slots > CW'(mem_acc);
        slots_d    = slots_q;
        if (mem_acc) slots_d[wr_ptr_q] = '{rd: mem_rd, data: mem_data};
        if (alu_acc) slots_d[wr_ptr_q + PW'(mem_acc)] = '{rd: alu_rd, data: alu_data};
        wr_ptr_d   = wr_ptr_q + PW'(mem_acc) + PW'(alu_acc);
        rd_ptr_d   = rd_ptr_q + PW'(deq);
        count_d    = count_q + CW'(mem_acc) + CW'(alu_acc) - CW'(deq);
        overflow_d = overflow_q || (mem_req && !mem_acc) || (alu_req && !alu_acc);
    end

    // Control state with asynchronous clear; pending entries are discarded on reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Entry storage is left uncleared; every consumer is qualified by count
    always_ff @(posedge clk) begin
        slots_q <= slots_d;
    end

    assign RegWrite       = count_q != '0;
    assign Write_register = RegWrite ? slots_q[rd_ptr_q].rd : '0;
    assign Write_data     = RegWrite ? slots_q[rd_ptr_q].data : '0;
    assign stall          = count_q > CW'(DEPTH - 2);
    assign overflow       = overflow_q;

    rf_wq_fwd_lookup #(.DEPTH(DEPTH)) u_fwd1 (
        .entries (slots_q),
        .head    (rd_ptr_q),
        .count   (count_q),
        .rs      (rs1),
        .hit     (fwd1_hit),
        .data    (fwd1_data)
    );

    rf_wq_fwd_lookup #(.DEPTH(DEPTH)) u_fwd2 (
        .entries (slots_q),
        .head    (rd_ptr_q),
        .count   (count_q),
        .rs      (rs2),
        .hit     (fwd2_hit),
        .data    (fwd2_data)
    );
endmodule

// File: tb/tb_rf_write_queue.sv
// tb_rf_write_queue: scoreboard bench for rf_write_queue against a queue-based reference model
module tb_rf_write_queue;
    localparam int DEPTH = 4;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    logic        clk = 0, reset = 1;
    logic        mem_valid = 0, alu_valid = 0;
    logic [4:0]  mem_rd = 0, alu_rd = 0, rs1 = 0, rs2 = 0;
    logic [31:0] mem_data = 0, alu_data = 0;
    logic        fwd1_hit, fwd2_hit, RegWrite, stall, overflow;
    logic [31:0] fwd1_data, fwd2_data, Write_data;
    logic [4:0]  Write_register;

    ent_t pend[$];
    ent_t exp_q[$];
    bit   ovf_m = 0;
    int   checks = 0, failures = 0;

    rf_write_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .rs1(rs1), .rs2(rs2),
        .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit),
        .fwd1_data(fwd1_data), .fwd2_data(fwd2_data),
        .RegWrite(RegWrite), .Write_register(Write_register), .Write_data(Write_data),
        .stall(stall), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic accept(input logic v, input logic [4:0] rd, input logic [31:0] d);
        if (v && rd != 0) begin
            if (pend.size() < DEPTH) begin
                pend.push_back('{rd, d});
                exp_q.push_back('{rd, d});
            end else begin
                ovf_m = 1;
            end
        end
    endtask

    function automatic logic [32:0] fwd_model(input logic [4:0] rs);
        logic [32:0] r = '0;
        if (rs != 0)
            foreach (pend[i])
                if (pend[i].rd == rs) r = {1'b1, pend[i].data};
        return r;
    endfunction

    // Reference model: head leaves, then mem and ALU requests take whatever room remains
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend.delete();
            exp_q.delete();
            ovf_m = 0;
        end else begin
            if (pend.size() != 0) void'(pend.pop_front());
            accept(mem_valid, mem_rd, mem_data);
            accept(alu_valid, alu_rd, alu_data);
        end
    end

    // Monitor: compare status/forwarding every cycle, pop scoreboard on each register-file write
    always @(negedge clk) begin : mon
        logic [32:0] f;
        ent_t e;
        chk("RegWrite", RegWrite, pend.size() != 0);
        chk("stall", stall, (DEPTH - pend.size()) < 2);
        chk("overflow", overflow, ovf_m);
        f = fwd_model(rs1);
        chk("fwd1_hit", fwd1_hit, f[32]);
        chk("fwd1_data", fwd1_data, f[31:0]);
        f = fwd_model(rs2);
        chk("fwd2_hit", fwd2_hit, f[32]);
        chk("fwd2_data", fwd2_data, f[31:0]);
        if (RegWrite) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL write_unexpected: got rd=%0d data=0x%0h expected no write", Write_register, Write_data);
            end else begin
                e = exp_q.pop_front();
                chk("Write_register", Write_register, e.rd);
                chk("Write_data", Write_data, e.data);
            end
        end
    end

    task automatic step(input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                        input logic av, input logic [4:0] ard, input logic [31:0] ad,
                        input logic [4:0] r1, input logic [4:0] r2);
        mem_valid = mv; mem_rd = mrd; mem_data = md;
        alu_valid = av; alu_rd = ard; alu_data = ad;
        rs1 = r1; rs2 = r2;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n, input logic [4:0] r1);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, r1, 0);
    endtask

    initial begin
        #2 reset = 0;
        #1;
        chk("reset_RegWrite", RegWrite, 0);
        chk("reset_stall", stall, 0);
        chk("reset_overflow", overflow, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1;

        step(0, 0, 0, 1, 5, 32'h1234, 5, 0);
        idle(3, 5);

        step(1, 3, 32'hA, 1, 3, 32'hB, 3, 3);
        idle(4, 3);

        step(0, 0, 0, 1, 0, 32'hFFFF, 0, 0);
        idle(3, 0);

        for (int i = 0; i < 5; i++) step(1, 5'(i + 1), 32'h100 + i, 1, 5'(i + 8), 32'h200 + i, 1, 8);
        idle(6, 2);

        for (int i = 0; i < 10; i++)
            step(1, 5'(i % 7 + 1), 32'h300 + i, 1, 5'(i % 5 + 20), 32'h400 + i, 5'(i % 7 + 1), 5'(i % 5 + 20));
        idle(6, 0);

        step(1, 9, 32'h99, 1, 10, 32'h1010, 0, 0);
        step(1, 12, 32'h1212, 1, 13, 32'h1313, 12, 10);
        mem_valid = 0; alu_valid = 0;
        chk("pre_reset_stall", stall, 1);
        #2 reset = 0;
        #1;
        chk("async_RegWrite", RegWrite, 0);
        chk("async_stall", stall, 0);
        chk("async_fwd1_hit", fwd1_hit, 0);
        chk("async_fwd2_hit", fwd2_hit, 0);
        chk("async_overflow", overflow, 0);
        @(posedge clk); #1 reset = 1;
        step(0, 0, 0, 1, 7, 32'h77, 7, 0);
        idle(3, 7);

        for (int i = 0; i < 300; i++)
            step($urandom_range(0, 9) < 6, 5'($urandom_range(0, 7)), $urandom,
                 $urandom_range(0, 9) < 6, 5'($urandom_range(0, 7)), $urandom,
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        idle(8, 0);
        chk("drain_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
